// File: rtl/counter_pkg.sv
// Shared constants for the generic up-counter primitive.
package counter_pkg;

    localparam int unsigned COUNTER_DEFAULT_WIDTH = 8;
    localparam int unsigned COUNTER_MAX_WIDTH     = 32;

endpackage

// File: rtl/counter.sv
// Free-running up-counter with enable, synchronous clear and sticky wrap flag.
// Optional combinational at_max output is enabled by defining COUNTER_AT_MAX_EN.
module counter
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
`ifdef COUNTER_AT_MAX_EN
    output logic             at_max,
`endif
    output logic             overflow
);

    if (WIDTH < 1 || WIDTH > COUNTER_MAX_WIDTH) begin : g_width_check
        $error("counter: WIDTH %0d outside 1..%0d", WIDTH, COUNTER_MAX_WIDTH);
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;

    // Clear beats enable; an enable coinciding with clear is dropped.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
            if (count_q == '1) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

`ifdef COUNTER_AT_MAX_EN
    assign at_max = (count_q == '1);
`endif

endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: three instances (WIDTH 3, 1, 8) against an arithmetic model.
module tb_counter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] en;
    logic [2:0] clr;
    logic [2:0] cnt3;
    logic [0:0] cnt1;
    logic [7:0] cnt8;
    logic [2:0] ov;
`ifdef COUNTER_AT_MAX_EN
    logic [2:0] am;
`endif

    always #5 clk = ~clk;

    counter #(.WIDTH(3)) u_c3 (
        .clk(clk), .reset_n(reset_n), .enable(en[0]), .clear(clr[0]), .count(cnt3),
`ifdef COUNTER_AT_MAX_EN
        .at_max(am[0]),
`endif
        .overflow(ov[0])
    );
    counter #(.WIDTH(1)) u_c1 (
        .clk(clk), .reset_n(reset_n), .enable(en[1]), .clear(clr[1]), .count(cnt1),
`ifdef COUNTER_AT_MAX_EN
        .at_max(am[1]),
`endif
        .overflow(ov[1])
    );
    counter #(.WIDTH(8)) u_c8 (
        .clk(clk), .reset_n(reset_n), .enable(en[2]), .clear(clr[2]), .count(cnt8),
`ifdef COUNTER_AT_MAX_EN
        .at_max(am[2]),
`endif
        .overflow(ov[2])
    );

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;
    int m_cnt[3];
    bit m_ov[3];

    function automatic int modof(input int i);
        case (i)
            0:       return 8;
            1:       return 2;
            default: return 256;
        endcase
    endfunction

    function automatic int dut_cnt(input int i);
        case (i)
            0:       return int'(cnt3);
            1:       return int'(cnt1);
            default: return int'(cnt8);
        endcase
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: count modulo 2^WIDTH, flag latches whenever the increment lands on zero.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_cnt[i] <= 0;
                m_ov[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (clr[i]) begin
                    m_cnt[i] <= 0;
                    m_ov[i]  <= 1'b0;
                end else if (en[i]) begin
                    m_cnt[i] <= (m_cnt[i] + 1) % modof(i);
                    if ((m_cnt[i] + 1) % modof(i) == 0) m_ov[i] <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model_count_w%0d", i), dut_cnt(i), m_cnt[i]);
                check($sformatf("model_overflow_w%0d", i), int'(ov[i]), int'(m_ov[i]));
`ifdef COUNTER_AT_MAX_EN
                check($sformatf("model_at_max_w%0d", i), int'(am[i]),
                      int'(m_cnt[i] == modof(i) - 1));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        en      = '0;
        clr     = '0;
        repeat (3) tick();
        check("reset_count_w3", int'(cnt3), 0);
        check("reset_count_w8", int'(cnt8), 0);
        check("reset_overflow", int'(ov), 0);
        reset_n = 1'b1;
        cmp_on  = 1'b1;

        // WIDTH=3 count-through: 1..7 then 0, flag rises only on the 8th edge.
        clr[0] = 1'b1;
        tick();
        check("w3_clear_count", int'(cnt3), 0);
        clr[0] = 1'b0;
        en[0]  = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("w3_run_count_%0d", k), int'(cnt3), k % 8);
            check($sformatf("w3_run_ovf_%0d", k), int'(ov[0]), (k == 8) ? 1 : 0);
        end
        tick();
        check("w3_ninth_count", int'(cnt3), 1);
        check("w3_ninth_ovf", int'(ov[0]), 1);

        // Hold at 4 for 10 cycles.
        repeat (3) tick();
        en[0] = 1'b0;
        repeat (10) tick();
        check("w3_hold_count", int'(cnt3), 4);
        check("w3_hold_ovf", int'(ov[0]), 1);

        // Clear and enable together at count 7.
        en[0] = 1'b1;
        repeat (3) tick();
        check("w3_pre_clear_count", int'(cnt3), 7);
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        en[0]  = 1'b0;
        check("w3_clear_prio_count", int'(cnt3), 0);
        check("w3_clear_prio_ovf", int'(ov[0]), 0);
        tick();
        check("w3_after_clear_ovf", int'(ov[0]), 0);

        // Async reset mid-count at count=5, overflow=1.
        en[0] = 1'b1;
        repeat (13) tick();
        en[0] = 1'b0;
        tick();
        check("w3_midcount_count", int'(cnt3), 5);
        check("w3_midcount_ovf", int'(ov[0]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_count", int'(cnt3), 0);
        check("async_reset_ovf", int'(ov[0]), 0);
        repeat (2) tick();
        reset_n = 1'b1;

        // WIDTH=1 toggle and sticky flag.
        clr[1] = 1'b1;
        tick();
        clr[1] = 1'b0;
        en[1]  = 1'b1;
        tick();
        check("w1_first_count", int'(cnt1), 1);
        check("w1_first_ovf", int'(ov[1]), 0);
        tick();
        check("w1_second_count", int'(cnt1), 0);
        check("w1_second_ovf", int'(ov[1]), 1);
        repeat (3) tick();
        check("w1_sticky_count", int'(cnt1), 1);
        check("w1_sticky_ovf", int'(ov[1]), 1);
        en[1] = 1'b0;

        // WIDTH=8 up to 255 and across the wrap.
        clr[2] = 1'b1;
        tick();
        clr[2] = 1'b0;
        en[2]  = 1'b1;
        repeat (255) tick();
        check("w8_max_count", int'(cnt8), 255);
        check("w8_max_ovf", int'(ov[2]), 0);
`ifdef COUNTER_AT_MAX_EN
        check("w8_at_max_high", int'(am[2]), 1);
`endif
        tick();
        en[2] = 1'b0;
        check("w8_wrap_count", int'(cnt8), 0);
        check("w8_wrap_ovf", int'(ov[2]), 1);
`ifdef COUNTER_AT_MAX_EN
        check("w8_at_max_low", int'(am[2]), 0);
`endif
        repeat (2) tick();

        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/counter.md
# counter

Parameterizable free-running up-counter with enable, synchronous clear and a sticky wrap (overflow) flag. It is the generic timing/indexing primitive used by the PS/2 receive path: one instance acts as the post-edge settle timer on the PS/2 clock line, and a 3-bit instance indexes the eight data bits of a frame. Overflow tells the parent that a full count period has elapsed since the last clear.

## Interface
- `WIDTH`, default 8: counter width in bits; legal range 1..32.
- `clk`  input  1  rising-edge system clock.
- `reset_n`  input  1  asynchronous, active-low reset.
- `enable`  input  1  count-enable; increments `count` on the next rising edge when high.
- `clear`  input  1  synchronous, active-high clear of `count` and `overflow`.
- `count`  output  WIDTH  current count value, registered.
- `overflow`  output  1  sticky wrap flag, registered.

## Operation
- Reset (`reset_n` low, asynchronous): `count` = 0, `overflow` = 0, held while low.
- Per rising edge, priority order:
  - `clear` high: `count` <= 0, `overflow` <= 0. Overrides `enable`.
  - else `enable` high: `count` <= `count` + 1, modulo 2^WIDTH. If `count` was all-ones, it wraps to 0 and `overflow` <= 1.
  - else: hold both.
- `overflow` is sticky: once set it stays 1 through further counting, including further wraps, until `clear` or reset.
- No saturation; counting continues after overflow.
- WIDTH = 1: `count` toggles 0→1→0. `overflow` sets on the second enabled cycle after a clear.
- Parent usage contract: in a 3-bit instance, `overflow` is 0 for the first 8 enabled increments after a clear. It first reads 1 after the 8th increment, once `count` is back at 0.

## Timing
- All outputs are registered. There are no combinational paths from inputs to outputs, except the optional `at_max` output.
- Latency: one clock from `enable` or `clear` to the updated `count`/`overflow`.
- `overflow` rises on the same edge on which `count` wraps to 0.
- `clear` and `enable` high together: clear wins, result is `count` = 0, `overflow` = 0. The enable is lost.
- Reset deassertion is asynchronous. The parent synchronizes `reset_n` release to `clk`.

## Configuration
- Macro `COUNTER_AT_MAX_EN`.
- Defined: adds output port `at_max` (1 bit). It is combinational and equals 1 exactly when `count` is all-ones. It is 0 in reset.
- Not defined: port absent. All other behaviour is identical.

## Structure
- Shared package `counter_pkg`, containing:
  - `COUNTER_DEFAULT_WIDTH` = 8;
  - `COUNTER_MAX_WIDTH` = 32.
- Single flat module. No sub-module is warranted.
- Include an elaboration-time check that rejects WIDTH outside 1..`COUNTER_MAX_WIDTH`.

## Test plan
- Reset: drive `reset_n` low mid-count (`count` = 5, `overflow` = 1) -> immediately `count` = 0, `overflow` = 0, without waiting for a clock edge.
- WIDTH = 3 count-through: clear, then 8 enabled cycles -> `count` = 1..7 then 0; `overflow` = 0 until the 8th edge, then 1; a 9th enable gives `count` = 1 with `overflow` still 1.
- Hold: WIDTH = 3, `count` = 4, `enable` low for 10 cycles -> `count` stays 4, `overflow` unchanged.
- Clear priority: `count` = 7, `clear` = 1 and `enable` = 1 on the same edge -> `count` = 0, `overflow` = 0, no wrap recorded.
- WIDTH = 1: clear, `enable` high for 2 cycles -> `count` 1 then 0, `overflow` sets on the 2nd edge and stays 1 while `enable` continues.
- `COUNTER_AT_MAX_EN` defined, WIDTH = 8: count to 255 -> `at_max` = 1 only while `count` = 255; on the next enabled edge `count` = 0, `at_max` = 0, `overflow` = 1.
